regfile_writeback_queue: RTL and testbench

Write side of the register file: buffers ALU/load results and retires them, one per cycle, into the register blocks. Each retirement drives the decoded write enables: BE plus one-hot RE[7:0] for the global block, and WE/WA for windowed registers. It also forwards pending, not-yet-retired values to the A/B read ports, so reads never see stale data. It sits between the execute/writeback pipeline stage and the register blocks.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/wbq_fwd_match.sv | 35 +++
 rtl/regfile_writeback_queue.sv | 132 +++++++++++++
 tb/tb_regfile_writeback_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address geometry, writeback entry type and
// the one-hot decoder used by the global register block.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned GLOBAL_REGS = 8;
  localparam int unsigned WB_DATA_W   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

  // One-hot select within the eight-entry global block
  function automatic logic [GLOBAL_REGS-1:0] onehot8(input logic [2:0] sel);
    logic [GLOBAL_REGS-1:0] res;
    res      = '0;
    res[sel] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-match search over the pending writeback entries for one read port.
module wbq_fwd_match
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_i,
  input  logic [DEPTH-1:0][DW-1:0]         data_i,
  input  logic [DEPTH-1:0]                 valid_i,
  input  logic [$clog2(DEPTH)-1:0]         head_i,
  input  logic [REG_ADDR_W-1:0]            raddr_i,
  output logic                             hit_o,
  output logic [DW-1:0]                    data_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest from the head so the last match (youngest) wins
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (raddr_i != '0 && valid_i[idx] && addr_i[idx] == raddr_i) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback queue: buffers results, retires one per cycle into the global or
// windowed register block, and forwards pending values to the A/B read ports.
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                   Clk,
  input  logic                   Clr,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [REG_ADDR_W-1:0]  InAddr,
  input  logic [DW-1:0]          InData,
  input  logic                   Hold,
  output logic [DW-1:0]          Out,
  output logic                   BE,
  output logic [GLOBAL_REGS-1:0] RE,
  output logic                   WE,
  output logic [REG_ADDR_W-1:0]  WA,
  input  logic [REG_ADDR_W-1:0]  RA,
  input  logic [REG_ADDR_W-1:0]  RB,
  output logic                   FwdAHit,
  output logic                   FwdBHit,
  output logic [DW-1:0]          FwdA,
  output logic [DW-1:0]          FwdB,
  output logic                   Empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DW-1:0]         data_q;

  logic                  push, retire;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [DW-1:0]         head_data;

  // Ready depends on registered count only: a pop never frees a slot same-cycle
  assign InReady = count_q < CW'(DEPTH);
  assign Empty   = count_q == '0;
  // r0 writes handshake but are dropped, keeping r0 hard-wired to zero
  assign push    = InValid && InReady && (InAddr != '0);
  assign retire  = !Empty && !Hold;

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];

  // Next-state for occupancy, pointers and per-entry valid bits
  always_comb begin
    count_d = count_q + CW'(push) - CW'(retire);
    head_d  = retire ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    valid_d = valid_q;
    if (retire) valid_d[head_q] = 1'b0;
    if (push)   valid_d[tail_q] = 1'b1;
  end

  // Control state, cleared asynchronously
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage; contents are only meaningful under their valid bit
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_q[tail_q] <= InAddr;
      data_q[tail_q] <= InData;
    end
  end

  // Decode the retiring head into global or windowed write enables
  always_comb begin
    Out = '0;
    BE  = 1'b0;
    RE  = '0;
    WE  = 1'b0;
    WA  = '0;
    if (retire) begin
      Out = head_data;
      if (head_addr < REG_ADDR_W'(GLOBAL_REGS)) begin
        BE = 1'b1;
        RE = onehot8(head_addr[2:0]);
      end else begin
        WE = 1'b1;
        WA = head_addr;
      end
    end
  end

  wbq_fwd_match #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fwd_a (
    .addr_i  (addr_q),
    .data_i  (data_q),
    .valid_i (valid_q),
    .head_i  (head_q),
    .raddr_i (RA),
    .hit_o   (FwdAHit),
    .data_o  (FwdA)
  );

  wbq_fwd_match #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fwd_b (
    .addr_i  (addr_q),
    .data_i  (data_q),
    .valid_i (valid_q),
    .head_i  (head_q),
    .raddr_i (RB),
    .hit_o   (FwdBHit),
    .data_o  (FwdB)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_regfile_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;

  logic          Clk, Clr;
  logic          InValid, InReady;
  logic [4:0]    InAddr;
  logic [DW-1:0] InData;
  logic          Hold;
  logic [DW-1:0] Out;
  logic          BE, WE;
  logic [7:0]    RE;
  logic [4:0]    WA, RA, RB;
  logic          FwdAHit, FwdBHit, Empty;
  logic [DW-1:0] FwdA, FwdB;

  regfile_writeback_queue #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .Clk     (Clk),
    .Clr     (Clr),
    .InValid (InValid),
    .InReady (InReady),
    .InAddr  (InAddr),
    .InData  (InData),
    .Hold    (Hold),
    .Out     (Out),
    .BE      (BE),
    .RE      (RE),
    .WE      (WE),
    .WA      (WA),
    .RA      (RA),
    .RB      (RB),
    .FwdAHit (FwdAHit),
    .FwdBHit (FwdBHit),
    .FwdA    (FwdA),
    .FwdB    (FwdB),
    .Empty   (Empty)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Forwarding per the model: youngest pending entry with that address
  task automatic fwd_model(input logic [4:0] ra_v, output logic hit, output logic [DW-1:0] val);
    hit = 1'b0;
    val = '0;
    if (ra_v != 0) begin
      foreach (q[i]) begin
        if (q[i].a == ra_v) begin
          hit = 1'b1;
          val = q[i].d;
        end
      end
    end
  endtask

  task automatic check_all(input logic h);
    logic          ret, hit_a, hit_b;
    logic [DW-1:0] va, vb;
    ret = (q.size() != 0) && !h;
    chk("in_ready", InReady, q.size() < DEPTH);
    chk("empty", Empty, q.size() == 0);
    if (ret && q[0].a < 8) begin
      chk("be", BE, 1);
      chk("re", RE, 64'(8'd1 << q[0].a[2:0]));
      chk("we", WE, 0);
      chk("wa", WA, 0);
      chk("out", Out, q[0].d);
    end else if (ret) begin
      chk("be", BE, 0);
      chk("re", RE, 0);
      chk("we", WE, 1);
      chk("wa", WA, q[0].a);
      chk("out", Out, q[0].d);
    end else begin
      chk("idle_en", {BE, RE, WE, WA}, 0);
      chk("idle_out", Out, 0);
    end
    fwd_model(RA, hit_a, va);
    fwd_model(RB, hit_b, vb);
    chk("fwd_a_hit", FwdAHit, hit_a);
    chk("fwd_a", FwdA, va);
    chk("fwd_b_hit", FwdBHit, hit_b);
    chk("fwd_b", FwdB, vb);
  endtask

  // One cycle: drive after the falling edge, check, then advance the model at the rising edge
  task automatic step(input logic v, input logic [4:0] a, input logic [DW-1:0] d,
                      input logic h, input logic [4:0] ra_v, input logic [4:0] rb_v,
                      output logic acc);
    logic ret;
    ent_t e;
    InValid = v; InAddr = a; InData = d; Hold = h; RA = ra_v; RB = rb_v;
    #1;
    check_all(h);
    acc = v && (q.size() < DEPTH);
    ret = (q.size() != 0) && !h;
    @(posedge Clk);
    if (ret) void'(q.pop_front());
    if (acc && a != 0) begin
      e.a = a;
      e.d = d;
      q.push_back(e);
    end
    @(negedge Clk);
  endtask

  logic          acc, pv;
  logic [4:0]    pa;
  logic [DW-1:0] pd;
  int            pushed;

  initial begin
    Clr = 1'b0; InValid = 0; InAddr = 0; InData = 0; Hold = 0; RA = 0; RB = 0;
    #1;
    chk("rst_ready", InReady, 1);
    chk("rst_empty", Empty, 1);
    chk("rst_en", {BE, RE, WE, WA}, 0);
    chk("rst_out", Out, 0);
    chk("rst_fwd", {FwdAHit, FwdBHit, FwdA, FwdB}, 0);
    @(negedge Clk);
    @(negedge Clk);
    Clr = 1'b1;

    // Single push to r5 retires next cycle on the global block
    step(1, 5'd5, 32'hDEADBEEF, 0, 5, 0, acc);
    InValid = 0; Hold = 0; RA = 0; RB = 0;
    #1;
    chk("t1_be", BE, 1);
    chk("t1_re", RE, 8'b0010_0000);
    chk("t1_out", Out, 32'hDEADBEEF);
    chk("t1_we", WE, 0);
    step(0, 0, 0, 0, 5, 0, acc);
    step(0, 0, 0, 0, 5, 0, acc);

    // Hold, fill with a duplicated address, then drain in order
    step(1, 5'd9, 32'h11, 1, 0, 0, acc);
    step(1, 5'd12, 32'h22, 1, 0, 0, acc);
    step(1, 5'd9, 32'h33, 1, 0, 0, acc);
    step(1, 5'd3, 32'h44, 1, 0, 0, acc);
    InValid = 0; Hold = 1; RA = 9; RB = 0;
    #1;
    chk("t2_ready", InReady, 0);
    chk("t2_fwda_hit", FwdAHit, 1);
    chk("t2_fwda", FwdA, 32'h33);
    chk("t2_fwdb_hit", FwdBHit, 0);
    step(0, 0, 0, 1, 9, 0, acc);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 9, 12, acc);

    // r0 handshakes but never enqueues
    step(1, 5'd0, 32'h55, 0, 0, 0, acc);
    chk("t3_acc", acc, 1);
    step(0, 0, 0, 0, 0, 0, acc);

    // Fill, then ten back-to-back pushes against a draining full queue
    for (int i = 0; i < 4; i++) step(1, 5'(8 + i), 32'(100 + i), 1, 8, 10, acc);
    pushed = 0;
    for (int i = 0; i < 40 && pushed < 10; i++) begin
      step(1, 5'(1 + pushed), 32'(200 + pushed), 0, 5'(1 + pushed), 9, acc);
      if (acc) pushed++;
    end
    chk("t4_pushed", pushed, 10);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, acc);

    // Hold mid-drain keeps the head and re-presents it
    step(1, 5'd8, 32'h1, 1, 0, 0, acc);
    step(1, 5'd9, 32'h2, 1, 0, 0, acc);
    step(0, 0, 0, 0, 9, 8, acc);
    step(0, 0, 0, 1, 9, 8, acc);
    step(0, 0, 0, 0, 9, 8, acc);
    step(0, 0, 0, 0, 9, 8, acc);

    // Asynchronous reset while entries are pending and BE is high
    step(1, 5'd2, 32'hA, 1, 0, 0, acc);
    step(1, 5'd10, 32'hB, 1, 0, 0, acc);
    step(1, 5'd3, 32'hC, 1, 0, 0, acc);
    InValid = 0; Hold = 0; RA = 2; RB = 10;
    #1;
    chk("t5_be_pre", BE, 1);
    #1;
    Clr = 1'b0;
    #1;
    chk("t5_en", {BE, RE, WE, WA}, 0);
    chk("t5_out", Out, 0);
    chk("t5_empty", Empty, 1);
    chk("t5_fwd", {FwdAHit, FwdBHit}, 0);
    q.delete();
    @(posedge Clk);
    @(negedge Clk);
    Clr = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2, 3, acc);

    // Random traffic with upstream holding a request until accepted
    pv = 0; pa = 0; pd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && $urandom_range(0, 9) < 7) begin
        pv = 1;
        pa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 12));
        pd = $urandom;
      end
      step(pv, pa, pd, $urandom_range(0, 9) < 3, 5'($urandom_range(0, 12)),
           5'($urandom_range(0, 12)), acc);
      if (acc) pv = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
